// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the branch resolve path: status-bus encodings,
// the resolver FSM state type and the default link register index.
package mips_ctrl_pkg;

   localparam logic [2:0] ST_NONE  = 3'b000;
   localparam logic [2:0] ST_BMN   = 3'b001;
   localparam logic [2:0] ST_BRZ   = 3'b010;
   localparam logic [2:0] ST_BZ    = 3'b011;
   localparam logic [2:0] ST_JMOR  = 3'b100;
   localparam logic [2:0] ST_JALM  = 3'b101;
   localparam logic [2:0] ST_JSPAL = 3'b110;
   localparam logic [2:0] ST_BEQ   = 3'b111;

   localparam int DEF_LINK_REG = 31;

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_MEM_WAIT = 1'b1
   } bru_state_e;

   // Statuses whose target comes back from data memory.
   function automatic logic is_mem_status(input logic [2:0] st);
      return (st == ST_BMN) || (st == ST_JMOR) || (st == ST_JALM) || (st == ST_JSPAL);
   endfunction

endpackage

// File: rtl/branch_flag_reg.sv
// Z/N status-flag register loaded by the ALU; readers always see the stored
// (pre-update) value in the cycle a write is presented.
module branch_flag_reg (
   input  logic clk,
   input  logic rst_n,
   input  logic we_i,
   input  logic z_i,
   input  logic n_i,
   output logic z_o,
   output logic n_o
);

   logic z_q;
   logic n_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_q <= 1'b0;
         n_q <= 1'b0;
      end else if (we_i) begin
         z_q <= z_i;
         n_q <= n_i;
      end
   end

   assign z_o = z_q;
   assign n_o = n_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves the next PC from the decoder status bus, fetching memory-indirect
// targets and stalling fetch meanwhile. BRANCH_RESOLVE_TIMEOUT_EN adds a wait limit.
module branch_resolve_unit
   import mips_ctrl_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int LINK_REG = DEF_LINK_REG,
   parameter int WAIT_MAX = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid,
   input  logic [2:0]      status,
   input  logic [XLEN-1:0] pc_plus4,
   input  logic [15:0]     imm,
   input  logic [25:0]     jtarget,
   input  logic [XLEN-1:0] rs_data,
   input  logic [XLEN-1:0] sp_data,
   input  logic            alu_zero,
   input  logic [XLEN-1:0] alu_result,
   input  logic            flag_we,
   input  logic            flag_z,
   input  logic            flag_n,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_valid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            busy,
   output logic            pc_we,
   output logic [XLEN-1:0] next_pc,
   output logic            link_we,
   output logic [4:0]      link_reg,
`ifdef BRANCH_RESOLVE_TIMEOUT_EN
   output logic            timeout_err,
`endif
   output logic [XLEN-1:0] link_data
);

   bru_state_e      state_q, state_d;
   logic [XLEN-1:0] next_pc_q, next_pc_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic [XLEN-1:0] pc4_q, pc4_d;
   logic            pc_we_q, pc_we_d;
   logic            link_we_q, link_we_d;
   logic            n_cap_q, n_cap_d;
   logic            cond_q, cond_d;
   logic            link_pend_q, link_pend_d;
   logic            z_flag, n_flag;
   logic [XLEN-1:0] beq_target;
   logic [XLEN-1:0] bz_target;

`ifdef BRANCH_RESOLVE_TIMEOUT_EN
   localparam int CW = $clog2(WAIT_MAX + 1);
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          timeout_q, timeout_d;
`endif

   branch_flag_reg u_flags (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (flag_we),
      .z_i   (flag_z),
      .n_i   (flag_n),
      .z_o   (z_flag),
      .n_o   (n_flag)
   );

   assign beq_target = pc_plus4 + {{(XLEN-18){imm[15]}}, imm, 2'b00};
   assign bz_target  = {pc_plus4[XLEN-1:28], jtarget, 2'b00};

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      next_pc_d   = next_pc_q;
      mem_addr_d  = mem_addr_q;
      pc4_d       = pc4_q;
      pc_we_d     = 1'b0;
      link_we_d   = 1'b0;
      n_cap_d     = n_cap_q;
      cond_d      = cond_q;
      link_pend_d = link_pend_q;
`ifdef BRANCH_RESOLVE_TIMEOUT_EN
      timeout_d   = 1'b0;
      wait_cnt_d  = '0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               pc4_d       = pc_plus4;
               n_cap_d     = n_flag;
               cond_d      = (status == ST_BMN);
               link_pend_d = (status == ST_JALM) || (status == ST_JSPAL);
               if (is_mem_status(status)) begin
                  state_d    = S_MEM_WAIT;
                  mem_addr_d = (status == ST_BMN)   ? alu_result :
                               (status == ST_JSPAL) ? sp_data    : rs_data;
               end else begin
                  pc_we_d = 1'b1;
                  unique case (status)
                     ST_BEQ:  next_pc_d = alu_zero ? beq_target : pc_plus4;
                     ST_BRZ:  next_pc_d = z_flag   ? rs_data    : pc_plus4;
                     ST_BZ:   next_pc_d = z_flag   ? bz_target  : pc_plus4;
                     default: next_pc_d = pc_plus4;
                  endcase
               end
            end
         end
         S_MEM_WAIT: begin
`ifdef BRANCH_RESOLVE_TIMEOUT_EN
            wait_cnt_d = wait_cnt_q + 1'b1;
`endif
            if (mem_valid) begin
               state_d   = S_IDLE;
               pc_we_d   = 1'b1;
               link_we_d = link_pend_q;
               next_pc_d = (!cond_q || n_cap_q) ? mem_rdata : pc4_q;
            end
`ifdef BRANCH_RESOLVE_TIMEOUT_EN
            else if (wait_cnt_q == CW'(WAIT_MAX - 1)) begin
               state_d   = S_IDLE;
               pc_we_d   = 1'b1;
               next_pc_d = pc4_q;
               timeout_d = 1'b1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         next_pc_q   <= '0;
         mem_addr_q  <= '0;
         pc4_q       <= '0;
         pc_we_q     <= 1'b0;
         link_we_q   <= 1'b0;
         n_cap_q     <= 1'b0;
         cond_q      <= 1'b0;
         link_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         next_pc_q   <= next_pc_d;
         mem_addr_q  <= mem_addr_d;
         pc4_q       <= pc4_d;
         pc_we_q     <= pc_we_d;
         link_we_q   <= link_we_d;
         n_cap_q     <= n_cap_d;
         cond_q      <= cond_d;
         link_pend_q <= link_pend_d;
      end
   end

`ifdef BRANCH_RESOLVE_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign timeout_err = timeout_q;
`endif

   assign busy      = (state_q == S_MEM_WAIT);
   assign mem_req   = busy;
   assign mem_addr  = mem_addr_q;
   assign pc_we     = pc_we_q;
   assign next_pc   = next_pc_q;
   assign link_we   = link_we_q;
   assign link_reg  = 5'(LINK_REG);
   assign link_data = pc4_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: table of single-cycle branches plus
// hand-written memory-indirect, flag-race, reset and (optional) timeout sequences.
module tb_branch_resolve_unit;
   import mips_ctrl_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            instr_valid = 1'b0;
   logic [2:0]      status = 3'b000;
   logic [XLEN-1:0] pc_plus4 = '0;
   logic [15:0]     imm = '0;
   logic [25:0]     jtarget = '0;
   logic [XLEN-1:0] rs_data = '0;
   logic [XLEN-1:0] sp_data = '0;
   logic            alu_zero = 1'b0;
   logic [XLEN-1:0] alu_result = '0;
   logic            flag_we = 1'b0;
   logic            flag_z = 1'b0;
   logic            flag_n = 1'b0;
   logic            mem_req;
   logic [XLEN-1:0] mem_addr;
   logic            mem_valid = 1'b0;
   logic [XLEN-1:0] mem_rdata = '0;
   logic            busy;
   logic            pc_we;
   logic [XLEN-1:0] next_pc;
   logic            link_we;
   logic [4:0]      link_reg;
   logic [XLEN-1:0] link_data;
`ifdef BRANCH_RESOLVE_TIMEOUT_EN
   logic            timeout_err;
`endif

   int n_vec = 0;
   int n_err = 0;

   branch_resolve_unit #(.XLEN(XLEN), .LINK_REG(31), .WAIT_MAX(15)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .status      (status),
      .pc_plus4    (pc_plus4),
      .imm         (imm),
      .jtarget     (jtarget),
      .rs_data     (rs_data),
      .sp_data     (sp_data),
      .alu_zero    (alu_zero),
      .alu_result  (alu_result),
      .flag_we     (flag_we),
      .flag_z      (flag_z),
      .flag_n      (flag_n),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_valid   (mem_valid),
      .mem_rdata   (mem_rdata),
      .busy        (busy),
      .pc_we       (pc_we),
      .next_pc     (next_pc),
      .link_we     (link_we),
      .link_reg    (link_reg),
`ifdef BRANCH_RESOLVE_TIMEOUT_EN
      .timeout_err (timeout_err),
`endif
      .link_data   (link_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Protocol guard: the bench must never present an instruction while busy.
   always @(negedge clk) begin
      if (rst_n && instr_valid && busy) begin
         n_err++;
         $display("FAIL protocol: instr_valid while busy");
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_flags(input logic z, input logic n);
      flag_we = 1'b1; flag_z = z; flag_n = n;
      step();
      flag_we = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic [2:0]  st;
      logic [31:0] pc4;
      logic [15:0] imm;
      logic [25:0] jt;
      logic [31:0] rs;
      logic        az;
      logic        z;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[9];

   // Memory-indirect sequence: waits = number of mem_req cycles before data returns.
   task automatic mem_seq(input string name, input logic [2:0] st, input logic [31:0] rs,
                          input logic [31:0] sp, input logic [31:0] alu, input logic [31:0] pc4,
                          input logic n, input int waits, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [31:0] exp_pc,
                          input logic exp_link);
      set_flags(1'b0, n);
      instr_valid = 1'b1; status = st; rs_data = rs; sp_data = sp;
      alu_result = alu; pc_plus4 = pc4;
      step();
      instr_valid = 1'b0;
      for (int i = 0; i < waits; i++) begin
         check({name, " mem_req"}, 32'(mem_req), 32'd1);
         check({name, " busy"}, 32'(busy), 32'd1);
         check({name, " mem_addr"}, mem_addr, exp_addr);
         check({name, " no early pc_we"}, 32'(pc_we), 32'd0);
         if (i == waits - 1) begin
            mem_valid = 1'b1; mem_rdata = rdata;
         end
         step();
      end
      mem_valid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      check({name, " pc_we"}, 32'(pc_we), 32'd1);
      check({name, " next_pc"}, next_pc, exp_pc);
      check({name, " link_we"}, 32'(link_we), 32'(exp_link));
      check({name, " mem_req dropped"}, 32'(mem_req), 32'd0);
      check({name, " busy dropped"}, 32'(busy), 32'd0);
      if (exp_link) begin
         check({name, " link_data"}, link_data, pc4);
         check({name, " link_reg"}, 32'(link_reg), 32'd31);
      end
      step();
      check({name, " pc_we pulse"}, 32'(pc_we), 32'd0);
   endtask

   initial begin
      vecs[0] = '{"beq taken",     ST_BEQ,  32'h0000_0100, 16'h0004, 26'h0,  32'h0,    1'b1, 1'b0, 32'h0000_0110};
      vecs[1] = '{"beq not taken", ST_BEQ,  32'h0000_0100, 16'h0004, 26'h0,  32'h0,    1'b0, 1'b0, 32'h0000_0100};
      vecs[2] = '{"beq backward",  ST_BEQ,  32'h0000_0100, 16'hFFFF, 26'h0,  32'h0,    1'b1, 1'b0, 32'h0000_00FC};
      vecs[3] = '{"beq wrap",      ST_BEQ,  32'h0001_0000, 16'h8000, 26'h0,  32'h0,    1'b1, 1'b0, 32'hFFFF_0000};
      vecs[4] = '{"bz taken",      ST_BZ,   32'h4000_0010, 16'h0000, 26'h10, 32'h0,    1'b0, 1'b1, 32'h4000_0040};
      vecs[5] = '{"brz taken",     ST_BRZ,  32'h0000_0104, 16'h0000, 26'h0,  32'h2000, 1'b0, 1'b1, 32'h0000_2000};
      vecs[6] = '{"brz not taken", ST_BRZ,  32'h0000_0300, 16'h0000, 26'h0,  32'h2000, 1'b0, 1'b0, 32'h0000_0300};
      vecs[7] = '{"bz not taken",  ST_BZ,   32'h4000_0010, 16'h0000, 26'h10, 32'h0,    1'b0, 1'b0, 32'h4000_0010};
      vecs[8] = '{"none",          ST_NONE, 32'h0000_0504, 16'h1234, 26'h3,  32'h77,   1'b1, 1'b1, 32'h0000_0504};

      repeat (2) step();
      rst_n = 1'b1;
      step();
      check("reset mem_req", 32'(mem_req), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset pc_we", 32'(pc_we), 32'd0);
      check("reset link_we", 32'(link_we), 32'd0);
      check("reset next_pc", next_pc, 32'd0);
      check("reset mem_addr", mem_addr, 32'd0);
      check("reset link_data", link_data, 32'd0);

      foreach (vecs[i]) begin
         set_flags(vecs[i].z, 1'b0);
         instr_valid = 1'b1; status = vecs[i].st; pc_plus4 = vecs[i].pc4;
         imm = vecs[i].imm; jtarget = vecs[i].jt; rs_data = vecs[i].rs;
         alu_zero = vecs[i].az;
         step();
         instr_valid = 1'b0;
         check({vecs[i].name, " pc_we"}, 32'(pc_we), 32'd1);
         check({vecs[i].name, " next_pc"}, next_pc, vecs[i].exp_pc);
         check({vecs[i].name, " link_we"}, 32'(link_we), 32'd0);
         check({vecs[i].name, " busy"}, 32'(busy), 32'd0);
         step();
         check({vecs[i].name, " pc_we pulse"}, 32'(pc_we), 32'd0);
      end

      mem_seq("jalm", ST_JALM, 32'h80, 32'h0, 32'h0, 32'h204, 1'b0, 3, 32'h1000, 32'h80, 32'h1000, 1'b1);
      mem_seq("bmn n0", ST_BMN, 32'h0, 32'h0, 32'h30, 32'h600, 1'b0, 1, 32'h500, 32'h30, 32'h600, 1'b0);
      mem_seq("bmn n1", ST_BMN, 32'h0, 32'h0, 32'h34, 32'h604, 1'b1, 2, 32'h500, 32'h34, 32'h500, 1'b0);
      mem_seq("jspal", ST_JSPAL, 32'h88, 32'h7000, 32'h0, 32'h208, 1'b0, 1, 32'h2400, 32'h7000, 32'h2400, 1'b1);
      mem_seq("jmor", ST_JMOR, 32'h90, 32'h7000, 32'h0, 32'h20C, 1'b0, 2, 32'h3300, 32'h90, 32'h3300, 1'b0);

      // Stray mem_valid while idle has no effect.
      mem_valid = 1'b1; mem_rdata = 32'h1234;
      step();
      mem_valid = 1'b0;
      check("idle mem_valid pc_we", 32'(pc_we), 32'd0);
      check("idle mem_valid mem_req", 32'(mem_req), 32'd0);

      // Back-to-back: second instruction presented while first pc_we is high.
      set_flags(1'b0, 1'b0);
      instr_valid = 1'b1; status = ST_BEQ; pc_plus4 = 32'h1000; imm = 16'h0010; alu_zero = 1'b1;
      step();
      status = ST_NONE; pc_plus4 = 32'h2004;
      check("b2b first pc_we", 32'(pc_we), 32'd1);
      check("b2b first next_pc", next_pc, 32'h1040);
      step();
      instr_valid = 1'b0;
      check("b2b second pc_we", 32'(pc_we), 32'd1);
      check("b2b second next_pc", next_pc, 32'h2004);
      step();

      // Flag race: Z written 0->1 together with brz uses old Z.
      flag_we = 1'b1; flag_z = 1'b1; flag_n = 1'b0;
      instr_valid = 1'b1; status = ST_BRZ; rs_data = 32'h2000; pc_plus4 = 32'h104;
      step();
      flag_we = 1'b0;
      check("race pc_we", 32'(pc_we), 32'd1);
      check("race old Z", next_pc, 32'h104);
      pc_plus4 = 32'h108;
      step();
      instr_valid = 1'b0;
      check("race new Z", next_pc, 32'h2000);
      step();

      // Reset during MEM_WAIT drops the pending instruction.
      instr_valid = 1'b1; status = ST_JALM; rs_data = 32'h80; pc_plus4 = 32'h204;
      step();
      instr_valid = 1'b0;
      step();
      check("pre-reset busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset mem_req", 32'(mem_req), 32'd0);
      check("async reset busy", 32'(busy), 32'd0);
      check("async reset pc_we", 32'(pc_we), 32'd0);
      mem_valid = 1'b1; mem_rdata = 32'h5555;
      step();
      #3 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         mem_valid = 1'b0;
         check("post-reset no pc_we", 32'(pc_we), 32'd0);
         check("post-reset no link_we", 32'(link_we), 32'd0);
         check("post-reset idle", 32'(busy), 32'd0);
      end

`ifdef BRANCH_RESOLVE_TIMEOUT_EN
      instr_valid = 1'b1; status = ST_JMOR; rs_data = 32'hA0; pc_plus4 = 32'h444;
      step();
      instr_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         check("timeout wait mem_req", 32'(mem_req), 32'd1);
         check("timeout wait no err", 32'(timeout_err), 32'd0);
         step();
      end
      check("timeout_err", 32'(timeout_err), 32'd1);
      check("timeout pc_we", 32'(pc_we), 32'd1);
      check("timeout next_pc", next_pc, 32'h444);
      check("timeout link_we", 32'(link_we), 32'd0);
      check("timeout busy", 32'(busy), 32'd0);
      check("timeout mem_req", 32'(mem_req), 32'd0);
      step();
      check("timeout_err pulse", 32'(timeout_err), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
